pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register. It is the successor to the fixed per-stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque data bus and a control bus with a valid/ready handshake, plus a synchronous flush.
- Provides an optional 2-entry skid buffer, so a stall can propagate upstream one cycle later without a combinational ready path.
- Every stage boundary is instantiated from this block. Only DATA_W, CTRL_W and SKID change per stage.

---
 rtl/pipe_stage_reg_pkg.sv | 34 +++
 rtl/pipe_stage_reg_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants: per-boundary bus widths, ctrl field layout
// and the occupancy encoding used by pipe_stage_reg.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam int IF2ID_DATA_W  = 64;
    localparam int IF2ID_CTRL_W  = 8;
    localparam int ID2EX_DATA_W  = 128;
    localparam int ID2EX_CTRL_W  = 8;
    localparam int EX2MEM_DATA_W = 96;
    localparam int EX2MEM_CTRL_W = 8;
    localparam int MEM2WB_DATA_W = 64;
    localparam int MEM2WB_CTRL_W = 8;

    // ctrl layout: {num_write[4:0], s_data_write[1:0], reg_write}
    localparam int CTRL_REG_WRITE    = 0;
    localparam int CTRL_S_DATA_WRITE = 1;
    localparam int CTRL_NUM_WRITE    = 3;
    localparam int CTRL_FIELDS_W     = 8;

    function automatic logic [CTRL_FIELDS_W-1:0] pack_ctrl(
        input logic       reg_write,
        input logic [1:0] s_data_write,
        input logic [4:0] num_write
    );
        return {num_write, s_data_write, reg_write};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid+ctrl+data holding register.
// kill beats load; kill clears valid and ctrl but leaves data stale.
module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              kill,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// synchronous flush and an optional 2-entry skid buffer.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    if (SKID != 0) begin : g_skid
        occ_t              state;
        occ_t              state_nxt;
        logic              in_fire;
        logic              main_load;
        logic              main_kill;
        logic              skid_load;
        logic              skid_kill;
        logic              skid_valid;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;
        logic [CTRL_W-1:0] main_in_ctrl;
        logic [DATA_W-1:0] main_in_data;

        always_ff @(posedge clock) begin
            if (!reset)
                state <= EMPTY;
            else
                state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            main_load = 1'b0;
            main_kill = 1'b0;
            skid_load = 1'b0;
            skid_kill = 1'b0;
            if (flush) begin
                state_nxt = EMPTY;
                main_kill = 1'b1;
                skid_kill = 1'b1;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            main_load = 1'b1;
                            state_nxt = ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_ready) begin
                            main_load = 1'b1;
                        end else if (in_fire) begin
                            skid_load = 1'b1;
                            state_nxt = FULL;
                        end else if (out_ready) begin
                            main_kill = 1'b1;
                            state_nxt = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_ready) begin
                            main_load = 1'b1;
                            skid_kill = 1'b1;
                            state_nxt = ONE;
                        end
                    end
                    default: state_nxt = EMPTY;
                endcase
            end
        end

        // ready comes from registered state only, never from out_ready
        always_comb begin
            in_ready  = reset && (state != FULL);
            occupancy = state;
        end

        assign in_fire      = in_valid & in_ready;
        assign main_in_ctrl = skid_valid ? skid_ctrl : in_ctrl;
        assign main_in_data = skid_valid ? skid_data : in_data;

        pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
            .clock   (clock),
            .reset   (reset),
            .load    (main_load),
            .kill    (main_kill),
            .in_ctrl (main_in_ctrl),
            .in_data (main_in_data),
            .valid   (out_valid),
            .ctrl    (out_ctrl),
            .data    (out_data)
        );

        pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .clock   (clock),
            .reset   (reset),
            .load    (skid_load),
            .kill    (skid_kill),
            .in_ctrl (in_ctrl),
            .in_data (in_data),
            .valid   (skid_valid),
            .ctrl    (skid_ctrl),
            .data    (skid_data)
        );
    end else begin : g_flop
        logic in_fire;
        logic out_fire;

        assign in_ready  = reset & (out_ready | ~out_valid);
        assign in_fire   = in_valid & in_ready;
        assign out_fire  = out_valid & out_ready;
        assign occupancy = {1'b0, out_valid};

        pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
            .clock   (clock),
            .reset   (reset),
            .load    (in_fire),
            .kill    (flush | (out_fire & ~in_fire)),
            .in_ctrl (in_ctrl),
            .in_data (in_data),
            .valid   (out_valid),
            .ctrl    (out_ctrl),
            .data    (out_data)
        );
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus,
// each tracked by a queue model of the held entries.
module tb_pipe_stage_reg;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready1, out_valid1;
    logic [7:0]  out_ctrl1;
    logic [31:0] out_data1;
    logic [1:0]  occupancy1;

    logic        in_ready0, out_valid0;
    logic [7:0]  out_ctrl0;
    logic [31:0] out_data0;
    logic [1:0]  occupancy0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  c;
        logic [31:0] d;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl1),
        .out_data  (out_data1),
        .occupancy (occupancy1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl0),
        .out_data  (out_data0),
        .occupancy (occupancy0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and update the queue models from the held inputs.
    task automatic tick();
        bit r1, r0, p1, p0;
        ent_t e;
        r1 = reset && (q1.size() < 2);
        r0 = reset && (out_ready || q0.size() == 0);
        p1 = out_ready && q1.size() > 0;
        p0 = out_ready && q0.size() > 0;
        e.c = in_ctrl;
        e.d = in_data;
        @(posedge clock);
        #1;
        if (!reset || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (p1) void'(q1.pop_front());
            if (p0) void'(q0.pop_front());
            if (in_valid && r1) q1.push_back(e);
            if (in_valid && r0) q0.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b1;
        in_ctrl = 8'hA5;
        in_data = 32'h1234;
        out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if (out_valid1 !== 1'b0 || out_ctrl1 !== 8'h00 || out_data1 !== 32'h0 ||
            occupancy1 !== 2'd0 || in_ready1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_skid1: v=%b c=%h d=%h occ=%0d rdy=%b, want all 0",
                     out_valid1, out_ctrl1, out_data1, occupancy1, in_ready1);
        end
        vectors++;
        if (out_valid0 !== 1'b0 || out_ctrl0 !== 8'h00 || occupancy0 !== 2'd0 ||
            in_ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_skid0: v=%b c=%h occ=%0d rdy=%b, want all 0",
                     out_valid0, out_ctrl0, occupancy0, in_ready0);
        end
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: rdy1=%b rdy0=%b, want 1 1", in_ready1, in_ready0);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = 32'(i);
            in_ctrl = 8'(8'h10 + i);
            tick();
            vectors++;
            if (out_valid1 !== 1'b1 || out_data1 !== 32'(i) || out_ctrl1 !== 8'(8'h10 + i) ||
                occupancy1 !== 2'd1 || in_ready1 !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_skid1[%0d]: v=%b d=%0d c=%h occ=%0d rdy=%b, want 1 %0d %h 1 1",
                         i, out_valid1, out_data1, out_ctrl1, occupancy1, in_ready1, i, 8'h10 + i);
            end
            vectors++;
            if (out_valid0 !== 1'b1 || out_data0 !== 32'(i)) begin
                miscompares++;
                $display("FAIL stream_skid0[%0d]: v=%b d=%0d, want 1 %0d", i, out_valid0, out_data0, i);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid1 !== 1'b0 || occupancy1 !== 2'd0 || out_ctrl1 !== 8'h00) begin
            miscompares++;
            $display("FAIL stream_drain: v=%b occ=%0d c=%h, want 0 0 00", out_valid1, occupancy1, out_ctrl1);
        end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hAAAA;
        in_ctrl = 8'h0A;
        tick();
        out_ready = 1'b0;
        in_data = 32'hBBBB;
        in_ctrl = 8'h0B;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (occupancy1 !== 2'd2 || in_ready1 !== 1'b0 || out_data1 !== 32'hAAAA ||
            out_ctrl1 !== 8'h0A) begin
            miscompares++;
            $display("FAIL stall_full: occ=%0d rdy=%b d=%h c=%h, want 2 0 aaaa 0a",
                     occupancy1, in_ready1, out_data1, out_ctrl1);
        end
        tick();
        vectors++;
        if (occupancy1 !== 2'd2 || out_data1 !== 32'hAAAA) begin
            miscompares++;
            $display("FAIL stall_hold: occ=%0d d=%h, want 2 aaaa", occupancy1, out_data1);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid1 !== 1'b1 || out_data1 !== 32'hBBBB || out_ctrl1 !== 8'h0B ||
            occupancy1 !== 2'd1 || in_ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_second: v=%b d=%h c=%h occ=%0d rdy=%b, want 1 bbbb 0b 1 1",
                     out_valid1, out_data1, out_ctrl1, occupancy1, in_ready1);
        end
        tick();
        vectors++;
        if (out_valid1 !== 1'b0 || occupancy1 !== 2'd0) begin
            miscompares++;
            $display("FAIL stall_empty: v=%b occ=%0d, want 0 0", out_valid1, occupancy1);
        end
    endtask

    task automatic test_flush_full();
        bit seen;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h1111;
        in_ctrl = 8'h11;
        tick();
        out_ready = 1'b0;
        in_data = 32'h2222;
        in_ctrl = 8'h22;
        tick();
        flush = 1'b1;
        in_data = 32'hDEAD;
        in_ctrl = 8'hDE;
        vectors++;
        if (occupancy1 !== 2'd2) begin
            miscompares++;
            $display("FAIL flush_setup: occ=%0d, want 2", occupancy1);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid1 !== 1'b0 || out_ctrl1 !== 8'h00 || occupancy1 !== 2'd0 ||
            in_ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full: v=%b c=%h occ=%0d rdy=%b, want 0 00 0 1",
                     out_valid1, out_ctrl1, occupancy1, in_ready1);
        end
        vectors++;
        if (out_valid0 !== 1'b0 || out_ctrl0 !== 8'h00 || occupancy0 !== 2'd0) begin
            miscompares++;
            $display("FAIL flush_skid0: v=%b c=%h occ=%0d, want 0 00 0",
                     out_valid0, out_ctrl0, occupancy0);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid1 || out_valid0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_leak: entry surfaced after flush (seen=%b), want 0", seen);
        end
    endtask

    task automatic test_bubble();
        logic [7:0] ctl[3];
        logic       vld[3];
        ctl[0] = 8'hFF; ctl[1] = 8'h5C; ctl[2] = 8'h81;
        vld[0] = 1'b1;  vld[1] = 1'b0;  vld[2] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = vld[i];
            in_ctrl = ctl[i];
            in_data = 32'(100 + i);
            tick();
            vectors++;
            if (out_valid1 !== vld[i] || out_ctrl1 !== (vld[i] ? ctl[i] : 8'h00) ||
                out_valid0 !== vld[i] || out_ctrl0 !== (vld[i] ? ctl[i] : 8'h00)) begin
                miscompares++;
                $display("FAIL bubble[%0d]: v1=%b c1=%h v0=%b c0=%h, want v=%b c=%h",
                         i, out_valid1, out_ctrl1, out_valid0, out_ctrl0,
                         vld[i], vld[i] ? ctl[i] : 8'h00);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_skid0();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hC0C0;
        in_ctrl = 8'h3C;
        tick();
        out_ready = 1'b0;
        in_data = 32'hD0D0;
        in_ctrl = 8'h3D;
        #1;
        vectors++;
        if (in_ready0 !== 1'b0 || occupancy0 !== 2'd1) begin
            miscompares++;
            $display("FAIL skid0_stall: rdy=%b occ=%0d, want 0 1", in_ready0, occupancy0);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL skid0_ready: rdy=%b, want 1", in_ready0);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'hD0D0 || out_ctrl0 !== 8'h3D) begin
            miscompares++;
            $display("FAIL skid0_reload: v=%b d=%h c=%h, want 1 d0d0 3d",
                     out_valid0, out_data0, out_ctrl0);
        end
        tick();
        tick();
    endtask

    task automatic test_random();
        bit         ev1, ev0, er1, er0;
        logic [7:0] ec1, ec0;
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_ctrl = 8'($urandom_range(0, 255));
            in_data = $urandom;
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 19) == 0);
            #1;
            ev1 = q1.size() != 0;
            ev0 = q0.size() != 0;
            ec1 = ev1 ? q1[0].c : 8'h00;
            ec0 = ev0 ? q0[0].c : 8'h00;
            er1 = q1.size() < 2;
            er0 = out_ready || !ev0;
            vectors++;
            if (out_valid1 !== ev1 || out_ctrl1 !== ec1 || (ev1 && out_data1 !== q1[0].d) ||
                occupancy1 !== 2'(q1.size()) || in_ready1 !== er1) begin
                miscompares++;
                $display("FAIL random_skid1[%0d]: v=%b c=%h d=%h occ=%0d rdy=%b, want v=%b c=%h d=%h occ=%0d rdy=%b",
                         n, out_valid1, out_ctrl1, out_data1, occupancy1, in_ready1,
                         ev1, ec1, ev1 ? q1[0].d : 32'h0, q1.size(), er1);
            end
            vectors++;
            if (out_valid0 !== ev0 || out_ctrl0 !== ec0 || (ev0 && out_data0 !== q0[0].d) ||
                occupancy0 !== 2'(q0.size()) || in_ready0 !== er0) begin
                miscompares++;
                $display("FAIL random_skid0[%0d]: v=%b c=%h d=%h occ=%0d rdy=%b, want v=%b c=%h d=%h occ=%0d rdy=%b",
                         n, out_valid0, out_ctrl0, out_data0, occupancy0, in_ready0,
                         ev0, ec0, ev0 ? q0[0].d : 32'h0, q0.size(), er0);
            end
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_full();
        test_bubble();
        test_skid0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
